// File: rtl/conv_pkg.sv
// Shared constants for the convolution input loader.
// Holds the state encoding, the default sizes and the TUSER field positions.
package conv_pkg;

  localparam int DEF_INW  = 12;
  localparam int DEF_R    = 9;
  localparam int DEF_C    = 8;
  localparam int DEF_MAXK = 4;

  localparam int TUSER_NEWW  = 0;
  localparam int TUSER_K_LSB = 1;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_LOAD_W = 2'd1;
  localparam state_t S_LOAD_X = 2'd2;
  localparam state_t S_DONE   = 2'd3;

endpackage

// File: rtl/memory_dual_port.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents are never cleared.
module memory_dual_port #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/conv_input_loader.sv
// AXI-Stream loader filling the W and X memories of the conv accelerator.
// Holds off the stream while the datapath works on a completed set.
module conv_input_loader
  import conv_pkg::*;
#(
  parameter int INW  = DEF_INW,
  parameter int R    = DEF_R,
  parameter int C    = DEF_C,
  parameter int MAXK = DEF_MAXK,
  localparam int XADDRW = $clog2(R*C),
  localparam int WADDRW = $clog2(MAXK*MAXK),
  localparam int KW     = $clog2(MAXK+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INW-1:0]    INPUT_TDATA,
  input  logic              INPUT_TVALID,
  input  logic [KW:0]       INPUT_TUSER,
  output logic              INPUT_TREADY,
  output logic              inputs_loaded,
  input  logic              compute_finished,
  output logic [KW-1:0]     K,
  input  logic [XADDRW-1:0] X_read_addr,
  output logic [INW-1:0]    X_data,
  input  logic [WADDRW-1:0] W_read_addr,
  output logic [INW-1:0]    W_data
);

  localparam int KKW = 2*KW;
  localparam logic [XADDRW-1:0] X_LAST = XADDRW'(R*C-1);

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WADDRW-1:0] w_cnt_q, w_cnt_d;
  logic [XADDRW-1:0] x_cnt_q, x_cnt_d;
  logic              loaded_q, loaded_d;

  logic              hs;
  logic              new_w;
  logic [KW-1:0]     k_raw, k_new;
  logic [KKW-1:0]    kk_last;
  logic              w_we, x_we;
  logic [WADDRW-1:0] w_waddr;
  logic [XADDRW-1:0] x_waddr;

  assign INPUT_TREADY = (state_q != S_DONE) && !reset;
  assign hs = INPUT_TVALID && INPUT_TREADY;

  assign new_w = INPUT_TUSER[TUSER_NEWW];
  assign k_raw = INPUT_TUSER[TUSER_K_LSB +: KW];
  assign kk_last = KKW'(k_q) * KKW'(k_q) - KKW'(1);

  always_comb begin
    k_new = k_raw;
    if (k_raw == '0)
      k_new = KW'(1);
    else if (k_raw > KW'(MAXK))
      k_new = KW'(MAXK);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    w_cnt_d = w_cnt_q;
    x_cnt_d = x_cnt_q;
    w_we    = 1'b0;
    x_we    = 1'b0;
    w_waddr = w_cnt_q;
    x_waddr = x_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs && new_w) begin
          k_d     = k_new;
          w_we    = 1'b1;
          w_waddr = '0;
          w_cnt_d = WADDRW'(1);
          x_cnt_d = '0;
          state_d = (k_new == KW'(1)) ? S_LOAD_X : S_LOAD_W;
        end else if (hs) begin
          x_we    = 1'b1;
          x_waddr = '0;
          x_cnt_d = XADDRW'(1);
          state_d = S_LOAD_X;
        end
      end
      S_LOAD_W: begin
        if (hs) begin
          w_we    = 1'b1;
          w_cnt_d = w_cnt_q + WADDRW'(1);
          if (KKW'(w_cnt_q) == kk_last) begin
            x_cnt_d = '0;
            state_d = S_LOAD_X;
          end
        end
      end
      S_LOAD_X: begin
        if (hs) begin
          x_we    = 1'b1;
          x_cnt_d = x_cnt_q + XADDRW'(1);
          if (x_cnt_q == X_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (compute_finished) begin
          state_d = S_IDLE;
          w_cnt_d = '0;
          x_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign loaded_d = (state_d == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      w_cnt_q  <= '0;
      x_cnt_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      w_cnt_q  <= w_cnt_d;
      x_cnt_q  <= x_cnt_d;
      loaded_q <= loaded_d;
    end
  end

  assign K = k_q;
  assign inputs_loaded = loaded_q;

  memory_dual_port #(
    .WIDTH (INW),
    .DEPTH (MAXK*MAXK),
    .AW    (WADDRW)
  ) u_w_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (INPUT_TDATA),
    .raddr (W_read_addr),
    .rdata (W_data)
  );

  memory_dual_port #(
    .WIDTH (INW),
    .DEPTH (R*C),
    .AW    (XADDRW)
  ) u_x_mem (
    .clk   (clk),
    .we    (x_we),
    .waddr (x_waddr),
    .wdata (INPUT_TDATA),
    .raddr (X_read_addr),
    .rdata (X_data)
  );

endmodule

// File: tb/tb_conv_input_loader.sv
// Randomized bench for conv_input_loader against a set-level memory model.
// Streams full and partial sets and reads both memories back.
module tb_conv_input_loader;

  localparam int INW    = 12;
  localparam int R      = 9;
  localparam int C      = 8;
  localparam int MAXK   = 4;
  localparam int NX     = R*C;
  localparam int XADDRW = $clog2(R*C);
  localparam int WADDRW = $clog2(MAXK*MAXK);
  localparam int KW     = $clog2(MAXK+1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [INW-1:0]    INPUT_TDATA = '0;
  logic              INPUT_TVALID = 1'b0;
  logic [KW:0]       INPUT_TUSER = '0;
  logic              INPUT_TREADY;
  logic              inputs_loaded;
  logic              compute_finished = 1'b0;
  logic [KW-1:0]     K;
  logic [XADDRW-1:0] X_read_addr = '0;
  logic [INW-1:0]    X_data;
  logic [WADDRW-1:0] W_read_addr = '0;
  logic [INW-1:0]    W_data;

  conv_input_loader #(
    .INW (INW), .R (R), .C (C), .MAXK (MAXK)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .INPUT_TDATA      (INPUT_TDATA),
    .INPUT_TVALID     (INPUT_TVALID),
    .INPUT_TUSER      (INPUT_TUSER),
    .INPUT_TREADY     (INPUT_TREADY),
    .inputs_loaded    (inputs_loaded),
    .compute_finished (compute_finished),
    .K                (K),
    .X_read_addr      (X_read_addr),
    .X_data           (X_data),
    .W_read_addr      (W_read_addr),
    .W_data           (W_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int ref_w [MAXK*MAXK];
  int ref_x [NX];
  int ref_k = 0;
  int wq[$];
  int xq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampk(input int k);
    if (k == 0) return 1;
    if (k > MAXK) return MAXK;
    return k;
  endfunction

  task automatic send_word(input int d, input int user, input int gap,
                           input bit cf);
    bit ok;
    INPUT_TVALID = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    INPUT_TDATA  = d[INW-1:0];
    INPUT_TUSER  = user[KW:0];
    INPUT_TVALID = 1'b1;
    compute_finished = cf;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = INPUT_TREADY;
    end
    if (!ok) chk("tready_timeout", 0, 1);
    @(posedge clk);
    #1;
    INPUT_TVALID = 1'b0;
    compute_finished = 1'b0;
  endtask

  // Streams wq (if new_w) then xq; stops early after 'limit' words.
  task automatic send_set(input bit new_w, input int k, input int limit,
                          input int gap_max, input int cf_at);
    int all[$];
    int nw, total, user;
    nw = new_w ? clampk(k) * clampk(k) : 0;
    all = {};
    if (new_w) foreach (wq[i]) all.push_back(wq[i]);
    foreach (xq[i]) all.push_back(xq[i]);
    total = nw + NX;
    for (int i = 0; i < total && i < limit; i++) begin
      user = (i == 0) ? ((k << 1) | int'(new_w)) : int'($urandom_range(0, 15));
      send_word(all[i], user, int'($urandom_range(0, gap_max)), i == cf_at);
      if (i == 0 && new_w) ref_k = clampk(k);
      if (i < nw) ref_w[i] = all[i];
      else ref_x[i-nw] = all[i];
      if (i == total - 1) chk("loaded_after_last", inputs_loaded, 1);
      else if (i >= total - 3) chk("loaded_early", inputs_loaded, 0);
    end
  endtask

  task automatic read_all();
    chk("k", K, ref_k);
    for (int i = 0; i < ref_k * ref_k; i++) begin
      W_read_addr = WADDRW'(i);
      @(posedge clk);
      #1;
      chk($sformatf("w[%0d]", i), W_data, ref_w[i]);
    end
    for (int i = 0; i < NX; i++) begin
      X_read_addr = XADDRW'(i);
      @(posedge clk);
      #1;
      chk($sformatf("x[%0d]", i), X_data, ref_x[i]);
    end
    chk("loaded_hold", inputs_loaded, 1);
    chk("tready_done", INPUT_TREADY, 0);
  endtask

  task automatic release_set();
    @(negedge clk);
    chk("tready_before_cf", INPUT_TREADY, 0);
    compute_finished = 1'b1;
    @(posedge clk);
    #1;
    compute_finished = 1'b0;
    chk("loaded_after_cf", inputs_loaded, 0);
    chk("tready_after_cf", INPUT_TREADY, 1);
  endtask

  task automatic fill_w(input int n, input int base);
    wq = {};
    for (int i = 0; i < n; i++)
      wq.push_back(base < 0 ? int'($urandom_range(0, 4095)) : base + i);
  endtask

  task automatic fill_x(input int base);
    xq = {};
    for (int i = 0; i < NX; i++)
      xq.push_back(base < 0 ? int'($urandom_range(0, 4095)) : base + i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int kr, nwr;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("tready_in_reset", INPUT_TREADY, 0);
    reset = 1'b0;
    #1;
    chk("rst_loaded", inputs_loaded, 0);
    chk("rst_k", K, 0);
    chk("rst_tready", INPUT_TREADY, 1);
    @(posedge clk);
    #1;

    fill_w(4, 1);
    fill_x(100);
    send_set(1'b1, 2, 1000, 0, -1);
    read_all();
    release_set();

    send_set(1'b1, 2, 1000, 3, -1);
    read_all();
    release_set();

    fill_x(500);
    send_set(1'b0, 5, 1000, 1, -1);
    read_all();
    release_set();

    fill_w(1, 7);
    fill_x(-1);
    send_set(1'b1, 1, 1000, 1, -1);
    read_all();
    release_set();

    fill_w(16, -1);
    fill_x(-1);
    send_set(1'b1, 4, 1000, 1, -1);
    read_all();
    release_set();

    fill_w(4, 40);
    fill_x(-1);
    send_set(1'b1, 2, 4 + 30, 1, -1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_k = 0;
    #1;
    chk("midrst_loaded", inputs_loaded, 0);
    chk("midrst_tready", INPUT_TREADY, 1);
    chk("midrst_k", K, 0);
    @(posedge clk);
    #1;
    fill_w(9, -1);
    fill_x(-1);
    send_set(1'b1, 3, 1000, 2, -1);
    read_all();
    release_set();

    fill_x(-1);
    send_set(1'b0, 0, 1000, 1, 9 + 20);
    repeat (5) @(posedge clk);
    #1;
    chk("cf_in_loadx_hold", inputs_loaded, 1);
    read_all();
    release_set();

    fill_w(1, 9);
    fill_x(-1);
    send_set(1'b1, 0, 1000, 0, -1);
    read_all();
    release_set();

    for (int s = 0; s < 4; s++) begin
      kr  = int'($urandom_range(0, 7));
      nwr = int'($urandom_range(0, 1));
      fill_w(clampk(kr) * clampk(kr), -1);
      fill_x(-1);
      send_set(nwr[0], kr, 1000, 2, -1);
      read_all();
      release_set();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
